// File: rtl/nn_pkg.sv
// Shared widths, state encoding and arithmetic types
// for the neuron multiply-accumulate front end.
package nn_pkg;

  localparam int X_W          = 8;
  localparam int W_W          = 12;
  localparam int PROD_W       = X_W + W_W;
  localparam int ACC_W        = 22;
  localparam int N_INPUTS_DEF = 784;

  typedef logic signed [X_W-1:0]    x_t;
  typedef logic signed [W_W-1:0]    w_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_mac_acc_if.sv
// Control, input-pair and result bundle between
// the neuron MAC and its producer/consumer.
interface neuron_mac_acc_if;
  import nn_pkg::*;

  logic start;
  acc_t bias;
  logic in_valid;
  logic in_ready;
  x_t   x;
  w_t   w;
  logic out_valid;
  logic out_ready;
  acc_t out_acc;
  acc_t out_relu;
  logic out_ovf;
  logic busy;

  modport master (
    output start, bias, in_valid, x, w, out_ready,
    input  in_ready, out_valid, out_acc, out_relu,
    input  out_ovf, busy
  );

  modport slave (
    input  start, bias, in_valid, x, w, out_ready,
    output in_ready, out_valid, out_acc, out_relu,
    output out_ovf, busy
  );

endinterface

// File: rtl/mult_8x12.sv
// Pipeline stage 1: registered exact signed
// activation x weight product with a valid bit.
module mult_8x12
  import nn_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  x_t    x,
  input  w_t    w,
  output prod_t prod_q,
  output logic  vld_q
);

  prod_t prod_d;
  logic  vld_d;

  // Capture a new product only on an accepted pair
  always_comb begin
    prod_d = prod_q;
    vld_d  = en;
    if (en) begin
      prod_d = prod_t'(x) * prod_t'(w);
    end
  end

  // Product and valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/neuron_mac_acc.sv
// Bias-seeded streaming MAC for one neuron: multiply,
// wrap-accumulate, then present sum, ReLU and overflow.
module neuron_mac_acc
  import nn_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF,
  parameter int CNT_W    = 10
) (
  input logic             clk,
  input logic             rst_n,
  neuron_mac_acc_if.slave bus
);

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_INPUTS);

  state_t           state_q, state_d;
  acc_t             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  acc_t             out_acc_q, out_acc_d;
  acc_t             out_relu_q, out_relu_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic  in_ready;
  logic  hs;
  prod_t prod_q;
  logic  prod_vld;
  acc_t  prod_ext;
  acc_t  sum;
  logic  step_ovf;

  assign in_ready = (state_q == ACCUM) && (cnt_q < N_LAST);
  assign hs       = in_ready && bus.in_valid;

  mult_8x12 u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (hs),
    .x      (bus.x),
    .w      (bus.w),
    .prod_q (prod_q),
    .vld_q  (prod_vld)
  );

  assign prod_ext = acc_t'(prod_q);
  assign sum      = acc_q + prod_ext;
  // Same operand signs but a flipped result sign
  assign step_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc_q[ACC_W-1]);

  // Next state, accumulate stage and result capture
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_relu_d  = out_relu_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (prod_vld) begin
      acc_d = sum;
      if (step_ovf) begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.bias;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (hs) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q == N_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_acc_d   = acc_d;
        out_relu_d  = acc_d[ACC_W-1] ? '0 : acc_d;
        out_ovf_d   = ovf_d;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_relu_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_relu_q  <= out_relu_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_relu  = out_relu_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Directed bench for neuron_mac_acc: a 4-input and
// an 8-input instance driven through their buses.
module tb_neuron_mac_acc;
  import nn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  neuron_mac_acc_if if4 ();
  neuron_mac_acc_if if8 ();

  neuron_mac_acc #(.N_INPUTS(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  neuron_mac_acc #(.N_INPUTS(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start4(input acc_t b);
    if4.bias  = b;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
  endtask

  task automatic feed4(input x_t xv, input w_t wv,
                       input int n, input bit gap,
                       output bit ok, output int cyc);
    int got;
    bit on;
    bit hs;
    got = 0;
    cyc = 0;
    on  = 1'b1;
    while (got < n && cyc < 100) begin
      if4.in_valid = on;
      if4.x = xv;
      if4.w = wv;
      hs = on && if4.in_ready;
      tick();
      if (hs) got++;
      cyc++;
      if (gap) on = !on;
    end
    if4.in_valid = 1'b0;
    ok = (got == n);
  endtask

  task automatic run8(input acc_t b, input x_t xv,
                      input w_t wv, output bit ok);
    int got;
    int cyc;
    bit hs;
    if8.bias  = b;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 100) begin
      if8.in_valid = 1'b1;
      if8.x = xv;
      if8.w = wv;
      hs = if8.in_ready;
      tick();
      if (hs) got++;
      cyc++;
    end
    if8.in_valid = 1'b0;
    cyc = 0;
    while (!if8.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    ok = (got == 8) && if8.out_valid;
  endtask

  task automatic wait_out4(output bit ok);
    int cyc;
    cyc = 0;
    while (!if4.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    ok = if4.out_valid;
  endtask

  task automatic accept4();
    if4.out_ready = 1'b1;
    tick();
    if4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (if4.in_ready !== 1'b0 || if4.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: rdy=%b busy=%b want 0 0",
               if4.in_ready, if4.busy);
    end
    total++;
    if (if4.out_valid !== 1'b0 || if4.out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: vld=%b ovf=%b want 0 0",
               if4.out_valid, if4.out_ovf);
    end
    total++;
    if (if4.out_acc !== 22'sd0 || if4.out_relu !== 22'sd0) begin
      bad++;
      $display("FAIL reset_acc: acc=%0d relu=%0d want 0 0",
               if4.out_acc, if4.out_relu);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int cyc;
    start4(22'sd0);
    total++;
    if (if4.busy !== 1'b1 || if4.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_accum: busy=%b rdy=%b want 1 1",
               if4.busy, if4.in_ready);
    end
    feed4(8'sd1, 12'sd1, 4, 1'b0, ok, cyc);
    total++;
    if (!ok || cyc !== 4) begin
      bad++;
      $display("FAIL basic_feed: ok=%b cyc=%0d want 1 4",
               ok, cyc);
    end
    total++;
    if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_k0: vld=%b rdy=%b want 0 0",
               if4.out_valid, if4.in_ready);
    end
    tick();
    total++;
    if (if4.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_k1: vld=%b want 0",
               if4.out_valid);
    end
    tick();
    total++;
    if (if4.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_k2: vld=%b want 1",
               if4.out_valid);
    end
    total++;
    if (if4.out_acc !== 22'sd4 || if4.out_relu !== 22'sd4 ||
        if4.out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL basic_res: acc=%0d relu=%0d ovf=%b want 4 4 0",
               if4.out_acc, if4.out_relu, if4.out_ovf);
    end
    accept4();
    total++;
    if (if4.out_valid !== 1'b0 || if4.busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: vld=%b busy=%b want 0 0",
               if4.out_valid, if4.busy);
    end
  endtask

  task automatic test_negative();
    bit ok;
    int cyc;
    start4(-22'sd5);
    feed4(-8'sd128, 12'sd2047, 4, 1'b0, ok, cyc);
    wait_out4(ok);
    total++;
    if (!ok || if4.out_acc !== -22'sd1048069 ||
        if4.out_relu !== 22'sd0 || if4.out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL neg_res: vld=%b acc=%0d relu=%0d ovf=%b want 1 -1048069 0 0",
               ok, if4.out_acc, if4.out_relu, if4.out_ovf);
    end
    accept4();
  endtask

  task automatic test_wrap();
    bit ok;
    run8(22'sd0, -8'sd128, -12'sd2048, ok);
    total++;
    if (!ok || if8.out_acc !== -22'sd2097152 ||
        if8.out_ovf !== 1'b1 || if8.out_relu !== 22'sd0) begin
      bad++;
      $display("FAIL wrap_res: vld=%b acc=%0d relu=%0d ovf=%b want 1 -2097152 0 1",
               ok, if8.out_acc, if8.out_relu, if8.out_ovf);
    end
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    run8(22'sd0, 8'sd1, 12'sd1, ok);
    total++;
    if (!ok || if8.out_acc !== 22'sd8 || if8.out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL wrap_clear: vld=%b acc=%0d ovf=%b want 1 8 0",
               ok, if8.out_acc, if8.out_ovf);
    end
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    start4(22'sd0);
    feed4(8'sd3, -12'sd7, 4, 1'b1, ok, cyc);
    total++;
    if (!ok || cyc !== 7) begin
      bad++;
      $display("FAIL bp_gaps: ok=%b cyc=%0d want 1 7", ok, cyc);
    end
    wait_out4(ok);
    total++;
    if (!ok || if4.out_acc !== -22'sd84 || if4.out_relu !== 22'sd0) begin
      bad++;
      $display("FAIL bp_res: vld=%b acc=%0d relu=%0d want 1 -84 0",
               ok, if4.out_acc, if4.out_relu);
    end
    for (int i = 0; i < 5; i++) begin
      if4.start = (i == 2);
      if4.bias  = 22'sd99;
      tick();
      total++;
      if (if4.out_valid !== 1'b1 || if4.out_acc !== -22'sd84 ||
          if4.in_ready !== 1'b0 || if4.busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d: vld=%b acc=%0d rdy=%b busy=%b want 1 -84 0 1",
                 i, if4.out_valid, if4.out_acc, if4.in_ready, if4.busy);
      end
    end
    if4.start = 1'b0;
    accept4();
    total++;
    if (if4.out_valid !== 1'b0 || if4.busy !== 1'b0 ||
        if4.out_acc !== -22'sd84) begin
      bad++;
      $display("FAIL bp_release: vld=%b busy=%b acc=%0d want 0 0 -84",
               if4.out_valid, if4.busy, if4.out_acc);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    start4(22'sd50);
    feed4(8'sd5, 12'sd5, 2, 1'b0, ok, cyc);
    rst_n = 1'b0;
    #1;
    total++;
    if (if4.out_acc !== 22'sd0 || if4.busy !== 1'b0 ||
        if4.in_ready !== 1'b0 || if4.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: acc=%0d busy=%b rdy=%b vld=%b want 0 0 0 0",
               if4.out_acc, if4.busy, if4.in_ready, if4.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start4(22'sd3);
    feed4(8'sd2, 12'sd3, 4, 1'b0, ok, cyc);
    wait_out4(ok);
    total++;
    if (!ok || if4.out_acc !== 22'sd27 || if4.out_relu !== 22'sd27) begin
      bad++;
      $display("FAIL rst_rerun: vld=%b acc=%0d relu=%0d want 1 27 27",
               ok, if4.out_acc, if4.out_relu);
    end
    accept4();
  endtask

  task automatic test_start_ignored();
    bit ok;
    int cyc;
    start4(22'sd100);
    feed4(8'sd1, 12'sd2, 2, 1'b0, ok, cyc);
    if4.bias  = -22'sd500;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    feed4(8'sd1, 12'sd2, 2, 1'b0, ok, cyc);
    wait_out4(ok);
    total++;
    if (!ok || if4.out_acc !== 22'sd108) begin
      bad++;
      $display("FAIL ign_accum: vld=%b acc=%0d want 1 108",
               ok, if4.out_acc);
    end
    if4.bias      = -22'sd9;
    if4.start     = 1'b1;
    if4.out_ready = 1'b1;
    tick();
    if4.start     = 1'b0;
    if4.out_ready = 1'b0;
    tick();
    total++;
    if (if4.busy !== 1'b0 || if4.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ign_done: busy=%b rdy=%b want 0 0",
               if4.busy, if4.in_ready);
    end
    start4(22'sd10);
    feed4(8'sd1, 12'sd1, 4, 1'b0, ok, cyc);
    wait_out4(ok);
    total++;
    if (!ok || if4.out_acc !== 22'sd14 || if4.out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ign_fresh: vld=%b acc=%0d ovf=%b want 1 14 0",
               ok, if4.out_acc, if4.out_ovf);
    end
    accept4();
  endtask

  initial begin
    if4.start = 1'b0;
    if4.bias = '0;
    if4.in_valid = 1'b0;
    if4.x = '0;
    if4.w = '0;
    if4.out_ready = 1'b0;
    if8.start = 1'b0;
    if8.bias = '0;
    if8.in_valid = 1'b0;
    if8.x = '0;
    if8.w = '0;
    if8.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_mac_acc.md
Name: neuron_mac_acc

Overview:
Streaming multiply-accumulate front end for one fully-connected neuron of the MNIST classifier. It accepts pixel/weight pairs on a valid/ready handshake and forms a signed 20-bit product for each pair. It accumulates the products into a 22-bit signed sum, with the adder result written back into the accumulator (20 + 22 -> 22 bits). After N_INPUTS products it presents the bias-seeded sum, a ReLU copy and an overflow flag to the activation/argmax stage.

Parameters:
N_INPUTS, 784, products accumulated per neuron evaluation
CNT_W, 10, input counter width (2^CNT_W > N_INPUTS)
X_W, 8, signed activation width
W_W, 12, signed weight width
PROD_W, 20, signed product width (X_W + W_W)
ACC_W, 22, signed accumulator width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; seeds accumulator with bias; honoured only in IDLE
bias  in  ACC_W  signed bias, sampled on accepted start
in_valid  in  1  x/w pair valid
in_ready  out  1  block accepts pair this cycle
x  in  X_W  signed activation
w  in  W_W  signed weight
out_valid  out  1  result valid, held until accepted
out_ready  in  1  downstream accepts result
out_acc  out  ACC_W  signed accumulated sum (wrapping)
out_relu  out  ACC_W  max(out_acc, 0)
out_ovf  out  1  sticky: any accumulate step overflowed signed ACC_W
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc, count, product reg, prod_vld, out_acc, out_relu, out_ovf = 0; in_ready=0, out_valid=0, busy=0. Reset takes effect mid-operation; the partial sum is discarded.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE: start=1 -> acc<=bias, count<=0, ovf<=0, go to ACCUM. start in any other state is ignored.
- ACCUM: in_ready = (count < N_INPUTS). Handshake = in_valid & in_ready.
  - On handshake: prod_reg <= x*w (signed, full PROD_W, exact), prod_vld<=1, count++. Otherwise prod_vld<=0.
  - Pipeline stage 2: if prod_vld, acc <= acc + sext(prod_reg) mod 2^ACC_W.
  - Overflow on a step: operand signs equal and result sign differs. ovf becomes sticky 1 on the first such step.
  - When the handshake makes count == N_INPUTS, go to DRAIN.
- DRAIN (one cycle): the final prod_vld is added to acc. Go to DONE with the same edge loading out_acc = final acc, out_relu = (acc[ACC_W-1] ? 0 : acc), out_ovf = ovf, out_valid=1.
- Latency: last input handshake at edge k -> out_valid=1 after edge k+2.
- DONE: outputs held stable while out_ready=0.
  - out_valid & out_ready -> out_valid<=0, go to IDLE. out_acc/out_relu/out_ovf keep their values until the next DONE load.
  - start asserted in the same cycle as the output handshake is ignored.
- Input gaps (in_valid=0) in ACCUM stall counting; no timeout.
- in_ready=0 in IDLE, DRAIN and DONE.
- Arithmetic is two's complement throughout. Max |product| = 2^18, so the product never clips. Only the accumulator wraps.

Decomposition:
- Shared package nn_pkg holds:
  - width constants X_W, W_W, PROD_W, ACC_W
  - N_INPUTS default
  - FSM state enum typedef (IDLE/ACCUM/DRAIN/DONE)
  - typedefs for signed product and accumulator
- One sub-module: mult_8x12, a registered signed X_W x W_W -> PROD_W multiplier forming pipeline stage 1.
- The accumulate adder and ovf detection stay inline.

Test Plan:
1. N_INPUTS=4, bias=0, four pairs x=1, w=1 back-to-back -> out_valid 2 cycles after last handshake; out_acc=4, out_relu=4, out_ovf=0.
2. N_INPUTS=4, bias=-5, four pairs x=-128, w=2047 -> out_acc=-1048069, out_relu=0, out_ovf=0.
3. N_INPUTS=8, bias=0, eight pairs x=-128, w=-2048 (product 262144) -> sum 2097152 wraps; out_acc=-2097152, out_ovf=1.
4. Backpressure, N_INPUTS=4:
   - in_valid toggled 1/0 each cycle -> count advances only on handshakes.
   - out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0, start ignored.
   - out_ready=1 -> IDLE next edge.
5. Reset mid-ACCUM: rst_n=0 after 2 of 4 inputs -> all outputs 0, busy=0 immediately. New run with bias=3 and x=2, w=3 x4 -> out_acc=27.
6. start pulsed during ACCUM and simultaneously with the DONE output handshake -> no effect. Next start in IDLE begins a fresh accumulation.
